multi_countdown: RTL and testbench
==================================

MULTI_COUNTDOWN -- requirements
Module: multi_countdown

Interface
REQ-001 The block SHALL have parameter N_CH, default 2, the number of independent countdown channels (players), legal range 2..8.
REQ-002 The block SHALL have parameter MIN_W, default 5, the minutes field width per channel.
REQ-003 The block SHALL have parameter MIN_MAX, default 30, the maximum loadable minutes (MIN_MAX <= 2^MIN_W-1).
REQ-004 The block SHALL have parameter INC_SEC, default 3, the increment in seconds applied on swap when the increment feature is compiled in (0..59).
REQ-005 The block SHALL have localparam SEL_W = max(1, clog2(N_CH)).
REQ-006 Port clk, input, 1, the only clock; all state SHALL change on its rising edge.
REQ-007 Port rst, input, 1; reset is synchronous and active-high.
REQ-008 Port tick, input, 1, one-cycle 1 Hz strobe.
REQ-009 Port set, input, 1, load preset into all channels.
REQ-010 Port preset_min, input, MIN_W, preset minutes.
REQ-011 Port run, input, 1, level: 1 = count, 0 = pause.
REQ-012 Port swap, input, 1, one-cycle pulse: pass turn to next channel.
REQ-013 Port active, output, SEL_W, index of the counting channel.
REQ-014 Port min_out, output, N_CH*MIN_W, packed minutes, channel i at bits [i*MIN_W +: MIN_W].
REQ-015 Port sec_out, output, N_CH*6, packed seconds 0..59, channel i at [i*6 +: 6].
REQ-016 Port timeout, output, N_CH, per-channel flag-fall indicator.
REQ-017 Port running, output, 1, high only in state RUN.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, READY, RUN, FLAG. All outputs SHALL be registered and SHALL reflect an input event one cycle after the sampling edge.
REQ-019 set SHALL have top priority in every state: load all channels to clamp(preset_min):00, clear timeout, set active=0, go to READY; clamp maps 0 to 1 and values above MIN_MAX to MIN_MAX.
REQ-020 READY with run=1 -> RUN; RUN with run=0 -> READY. Channel values SHALL be held in READY.
REQ-021 In RUN on tick, the active channel only: sec>0 -> sec-1; sec=0 and min>0 -> min-1, sec=59. All other channels SHALL hold.
REQ-022 When a decrement produces 00:00, timeout[active] SHALL be set in the same update and the state SHALL go to FLAG.
REQ-023 In FLAG, channel values, active and timeout SHALL hold; tick, run and swap SHALL be ignored; only set or rst exits.
REQ-024 swap in RUN or READY SHALL set active to active+1, wrapping N_CH-1 -> 0; swap in IDLE or FLAG SHALL be ignored.
REQ-025 tick and swap in the same RUN cycle: the decrement SHALL apply to the old active channel, then the swap SHALL apply; if that decrement reaches 00:00, FLAG SHALL win and swap SHALL be dropped.
REQ-026 tick SHALL be ignored outside RUN; tick during set SHALL be ignored.

Reset
REQ-027 rst SHALL override set and all other inputs: state IDLE, active=0, every min_out/sec_out field 0, timeout=0, running=0.
REQ-028 rst asserted mid-RUN SHALL take effect at the next clock edge with no partial decrement.

Configuration
REQ-029 Macro FISCHER_INCREMENT_EN defined: swap in RUN (not READY) SHALL add INC_SEC seconds to the channel being left, after any same-cycle decrement, with seconds carry into minutes, saturating at (2^MIN_W-1):59.
REQ-030 Macro FISCHER_INCREMENT_EN undefined: swap SHALL change only active; the INC_SEC parameter SHALL have no effect.

Verification
REQ-031 rst; set with preset_min=5 -> all channels 05:00, active=0, state READY, timeout=0.
REQ-032 run=1, 61 ticks -> ch0 03:59, ch1 05:00; run=0, 10 ticks -> ch0 unchanged.
REQ-033 ch0 at 00:01 in RUN, tick+swap same cycle -> ch0 00:00, timeout=01, state FLAG, active=0, further ticks/swaps no effect.
REQ-034 FISCHER_INCREMENT_EN, INC_SEC=3, ch0 at 02:58, swap -> ch0 03:01, active=1; undefined -> ch0 02:58, active=1.
REQ-035 N_CH=3: three swaps in READY -> active 1,2,0; preset_min=0 -> 01:00; preset_min=31 -> 30:00.

Source files
------------

// File: rtl/multi_countdown.sv
// multi_countdown: multi-player countdown clock with per-channel minutes/seconds,
// turn passing via swap and per-channel flag-fall (timeout) detection.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset (overrides everything)
//   tick       - one-cycle 1 Hz strobe, decrements the active channel in RUN
//   set        - load clamp(preset_min):00 into all channels, go to READY
//   preset_min - preset minutes (0 loads 1, above MIN_MAX loads MIN_MAX)
//   run        - level: 1 = count, 0 = pause
//   swap       - one-cycle pulse, pass the turn to the next channel
//   active     - index of the counting channel
//   min_out    - packed minutes, channel i at [i*MIN_W +: MIN_W]
//   sec_out    - packed seconds, channel i at [i*6 +: 6]
//   timeout    - per-channel flag-fall indicator
//   running    - high only in RUN
//
// Optional macro FISCHER_INCREMENT_EN: a swap in RUN adds INC_SEC seconds to
// the channel being left, saturating at (2^MIN_W-1):59.
module multi_countdown #(
    parameter int N_CH    = 2,
    parameter int MIN_W   = 5,
    parameter int MIN_MAX = 30,
    parameter int INC_SEC = 3,
    localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  set,
    input  logic [MIN_W-1:0]      preset_min,
    input  logic                  run,
    input  logic                  swap,
    output logic [SEL_W-1:0]      active,
    output logic [N_CH*MIN_W-1:0] min_out,
    output logic [N_CH*6-1:0]     sec_out,
    output logic [N_CH-1:0]       timeout,
    output logic                  running
);
    localparam logic [MIN_W-1:0] MIN_TOP = '1;

    if (INC_SEC < 0 || INC_SEC > 59) begin : g_bad_inc
        $error("INC_SEC must be 0..59");
    end
    if (MIN_MAX < 1 || MIN_MAX > (1 << MIN_W) - 1) begin : g_bad_max
        $error("MIN_MAX must fit in MIN_W bits");
    end

    typedef enum logic [1:0] {IDLE, READY, RUN, FLAG} state_t;

    state_t           state, state_n;
    logic [MIN_W-1:0] mins   [N_CH];
    logic [MIN_W-1:0] mins_n [N_CH];
    logic [5:0]       secs   [N_CH];
    logic [5:0]       secs_n [N_CH];
    logic [SEL_W-1:0] active_n, active_inc;
    logic [N_CH-1:0]  timeout_n;
    logic [MIN_W-1:0] preset_clamped;
`ifdef FISCHER_INCREMENT_EN
    logic [6:0]       sum;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_pack
        assign min_out[i*MIN_W +: MIN_W] = mins[i];
        assign sec_out[i*6 +: 6]         = secs[i];
    end

    assign active_inc     = (active == SEL_W'(N_CH - 1)) ? '0 : active + SEL_W'(1);
    assign preset_clamped = (preset_min == '0) ? MIN_W'(1) :
                            (preset_min > MIN_W'(MIN_MAX)) ? MIN_W'(MIN_MAX) : preset_min;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            active  <= '0;
            timeout <= '0;
            running <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                mins[i] <= '0;
                secs[i] <= '0;
            end
        end else begin
            state   <= state_n;
            active  <= active_n;
            timeout <= timeout_n;
            running <= (state_n == RUN);
            mins    <= mins_n;
            secs    <= secs_n;
        end
    end

    always_comb begin
        state_n   = state;
        active_n  = active;
        timeout_n = timeout;
        mins_n    = mins;
        secs_n    = secs;
`ifdef FISCHER_INCREMENT_EN
        sum       = '0;
`endif
        if (set) begin
            state_n   = READY;
            active_n  = '0;
            timeout_n = '0;
            for (int i = 0; i < N_CH; i++) begin
                mins_n[i] = preset_clamped;
                secs_n[i] = '0;
            end
        end else begin
            case (state)
                READY: begin
                    state_n  = run ? RUN : READY;
                    active_n = swap ? active_inc : active;
                end
                RUN: begin
                    state_n = run ? RUN : READY;
                    if (tick) begin
                        secs_n[active] = (secs[active] != '0) ? secs[active] - 6'd1 : 6'd59;
                        mins_n[active] = (secs[active] != '0) ? mins[active] : mins[active] - MIN_W'(1);
                        // 00:01 -> 00:00 is the only way to reach zero; FLAG wins over swap
                        if (secs[active] == 6'd1 && mins[active] == '0) begin
                            timeout_n[active] = 1'b1;
                            state_n           = FLAG;
                        end
                    end
                    if (swap && state_n != FLAG) begin
                        active_n = active_inc;
`ifdef FISCHER_INCREMENT_EN
                        sum = {1'b0, secs_n[active]} + 7'(INC_SEC);
                        if (sum >= 7'd60) begin
                            if (mins_n[active] == MIN_TOP) begin
                                secs_n[active] = 6'd59;
                            end else begin
                                mins_n[active] = mins_n[active] + MIN_W'(1);
                                secs_n[active] = 6'(sum - 7'd60);
                            end
                        end else begin
                            secs_n[active] = sum[5:0];
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_countdown.sv
// tb_multi_countdown: checks two instances (2 and 3 channels) against a seconds-based model.
module tb_multi_countdown;
    localparam int CAP = 31 * 60 + 59;
    localparam int INC = 3;

    logic       clk = 0, rst = 0, set = 0, tick = 0, run = 0, swap = 0;
    logic [4:0] preset = '0;

    logic        a2, r2, r3;
    logic [1:0]  a3, to2;
    logic [2:0]  to3;
    logic [9:0]  m2;
    logic [14:0] m3;
    logic [11:0] s2;
    logic [17:0] s3;

    int errors = 0, checks = 0;
    bit cmp_en = 0;

    // model: remaining time in plain seconds, mode 0 idle / 1 ready / 2 run / 3 flag
    int t   [2][8];
    int tov [2][8];
    int md  [2];
    int act [2];
    int nch [2] = '{2, 3};

    multi_countdown #(.N_CH(2)) d2 (
        .clk(clk), .rst(rst), .tick(tick), .set(set), .preset_min(preset), .run(run), .swap(swap),
        .active(a2), .min_out(m2), .sec_out(s2), .timeout(to2), .running(r2));

    multi_countdown #(.N_CH(3)) d3 (
        .clk(clk), .rst(rst), .tick(tick), .set(set), .preset_min(preset), .run(run), .swap(swap),
        .active(a3), .min_out(m3), .sec_out(s3), .timeout(to3), .running(r3));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    function automatic int fmin(int k, int i);
        return k == 0 ? int'((m2 >> (i * 5)) & 10'd31) : int'((m3 >> (i * 5)) & 15'd31);
    endfunction

    function automatic int fsec(int k, int i);
        return k == 0 ? int'((s2 >> (i * 6)) & 12'd63) : int'((s3 >> (i * 6)) & 18'd63);
    endfunction

    always @(posedge clk) begin
        int p, o;
        bit fl;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                md[k] = 0;
                act[k] = 0;
                for (int i = 0; i < 8; i++) begin t[k][i] = 0; tov[k][i] = 0; end
            end else if (set) begin
                p = preset == 0 ? 1 : (preset > 30 ? 30 : int'(preset));
                for (int i = 0; i < 8; i++) begin t[k][i] = i < nch[k] ? p * 60 : 0; tov[k][i] = 0; end
                act[k] = 0;
                md[k] = 1;
            end else if (md[k] == 1) begin
                if (swap) act[k] = (act[k] + 1) % nch[k];
                if (run) md[k] = 2;
            end else if (md[k] == 2) begin
                o = act[k];
                fl = 0;
                if (tick) begin
                    t[k][o] = t[k][o] - 1;
                    if (t[k][o] == 0) begin tov[k][o] = 1; md[k] = 3; fl = 1; end
                end
                if (!fl) begin
                    if (!run) md[k] = 1;
                    if (swap) begin
`ifdef FISCHER_INCREMENT_EN
                        t[k][o] = (t[k][o] + INC > CAP) ? CAP : t[k][o] + INC;
`endif
                        act[k] = (o + 1) % nch[k];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < nch[k]; i++) begin
                    chk($sformatf("min[%0d][%0d]", k, i), fmin(k, i), t[k][i] / 60);
                    chk($sformatf("sec[%0d][%0d]", k, i), fsec(k, i), t[k][i] % 60);
                    chk($sformatf("timeout[%0d][%0d]", k, i), k == 0 ? int'(to2[i]) : int'(to3[i]), tov[k][i]);
                end
                chk($sformatf("active[%0d]", k), k == 0 ? int'(a2) : int'(a3), act[k]);
                chk($sformatf("running[%0d]", k), k == 0 ? int'(r2) : int'(r3), md[k] == 2 ? 1 : 0);
            end
        end
    end

    task automatic cyc(input bit r, input bit s, input bit tk, input bit rn, input bit sw, input int p);
        rst = r; set = s; tick = tk; run = rn; swap = sw; preset = 5'(p);
        @(posedge clk);
        #1;
        rst = 0; set = 0; tick = 0; swap = 0;
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0);
        cmp_en = 1;
        cyc(1, 1, 1, 1, 1, 9);
        chk("lit_rst_min0", fmin(0, 0), 0);
        chk("lit_rst_sec1", fsec(0, 1), 0);
        chk("lit_rst_run", int'(r2), 0);
        chk("lit_rst_act", int'(a2), 0);

        cyc(0, 1, 0, 0, 0, 5);
        chk("lit_set_min0", fmin(0, 0), 5);
        chk("lit_set_min1", fmin(0, 1), 5);
        chk("lit_set_sec0", fsec(0, 0), 0);
        chk("lit_set_run", int'(r2), 0);
        chk("lit_set_to", int'(to2), 0);

        cyc(0, 0, 0, 1, 0, 0);
        chk("lit_running", int'(r2), 1);
        repeat (61) cyc(0, 0, 1, 1, 0, 0);
        chk("lit_61_min0", fmin(0, 0), 3);
        chk("lit_61_sec0", fsec(0, 0), 59);
        chk("lit_61_min1", fmin(0, 1), 5);
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit_pause_run", int'(r2), 0);
        repeat (10) cyc(0, 0, 1, 0, 0, 0);
        chk("lit_pause_sec0", fsec(0, 0), 59);

        cyc(0, 0, 0, 0, 1, 0);
        chk("lit_swap1_n3", int'(a3), 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("lit_swap2_n3", int'(a3), 2);
        cyc(0, 0, 0, 0, 1, 0);
        chk("lit_swap3_n3", int'(a3), 0);
        chk("lit_swap3_n2", int'(a2), 1);

        cyc(0, 1, 0, 0, 0, 3);
        cyc(0, 0, 0, 1, 0, 0);
        repeat (2) cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("lit_inc_act", int'(a2), 1);
`ifdef FISCHER_INCREMENT_EN
        chk("lit_inc_min0", fmin(0, 0), 3);
        chk("lit_inc_sec0", fsec(0, 0), 1);
`else
        chk("lit_inc_min0", fmin(0, 0), 2);
        chk("lit_inc_sec0", fsec(0, 0), 58);
`endif

        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0);
        repeat (59) cyc(0, 0, 1, 1, 0, 0);
        chk("lit_pre_flag_sec0", fsec(0, 0), 1);
        cyc(0, 0, 1, 1, 1, 0);
        chk("lit_flag_sec0", fsec(0, 0), 0);
        chk("lit_flag_to", int'(to2), 1);
        chk("lit_flag_act", int'(a2), 0);
        chk("lit_flag_run", int'(r2), 0);
        repeat (4) cyc(0, 0, 1, 1, 1, 0);
        cyc(0, 0, 1, 0, 1, 0);
        chk("lit_flag_hold_act", int'(a2), 0);
        chk("lit_flag_hold_min1", fmin(0, 1), 1);

        cyc(0, 1, 0, 0, 0, 0);
        chk("lit_clamp0", fmin(0, 0), 1);
        chk("lit_clamp0_to", int'(to2), 0);
        cyc(0, 1, 0, 0, 0, 31);
        chk("lit_clamp31", fmin(1, 2), 30);

        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 1, 7);
        chk("lit_set_prio_min0", fmin(0, 0), 7);
        chk("lit_set_prio_sec0", fsec(0, 0), 0);

        cyc(0, 0, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 1, 1, 0, 0);
        cyc(1, 0, 1, 1, 1, 0);
        chk("lit_rst_run_min0", fmin(0, 0), 0);
        chk("lit_rst_run_r", int'(r2), 0);
        repeat (3) cyc(0, 0, 1, 1, 1, 0);
        chk("lit_idle_act", int'(a2), 0);

        cyc(0, 1, 0, 0, 0, 30);
        cyc(0, 0, 0, 1, 0, 0);
        repeat (90) cyc(0, 0, 0, 1, 1, 0);
        chk("lit_sat_act", int'(a2), 0);
`ifdef FISCHER_INCREMENT_EN
        chk("lit_sat_min0", fmin(0, 0), 31);
        chk("lit_sat_sec0", fsec(0, 0), 59);
`else
        chk("lit_sat_min0", fmin(0, 0), 30);
        chk("lit_sat_sec0", fsec(0, 0), 0);
`endif

        repeat (400) cyc($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0, 1'($urandom),
                         $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 31));
        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0);
        repeat (62) cyc(0, 0, 1, 1, $urandom_range(0, 3) == 0, 0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
